mips_id_stage: RTL and testbench

//   Decode stage directly downstream of the IF stage. Contains the IF/ID pipeline latch
//   (Instruction_F/PcPlus4_F), a 32x32 register file with a write-back port and

---
 rtl/mips_id_stage_if.sv | 36 +++
 rtl/mips_id_stage.sv | 103 ++++++++++
 tb/tb_mips_id_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mips_id_stage_if.sv
// IF/ID, hazard and write-back signals seen by the decode stage, grouped as one bundle.
// slave is the decode stage's view; master is the view of its neighbours.
interface mips_id_stage_if #(
   parameter int DW = 32
);
   logic [DW-1:0] Instruction_F;
   logic [DW-1:0] PcPlus4_F;
   logic          stall_D;
   logic          flush_D;
   logic          RegWrite_W;
   logic [4:0]    WriteReg_W;
   logic [DW-1:0] Result_W;
   logic [DW-1:0] Instruction_D;
   logic [DW-1:0] PcPlus4_D;
   logic          valid_D;
   logic [4:0]    Rs_D;
   logic [4:0]    Rt_D;
   logic [4:0]    Rd_D;
   logic [DW-1:0] RD1_D;
   logic [DW-1:0] RD2_D;
   logic [DW-1:0] SignImm_D;
   logic [DW-1:0] pc_branch;
   logic          branch;

   modport slave (
      input  Instruction_F, PcPlus4_F, stall_D, flush_D, RegWrite_W, WriteReg_W, Result_W,
      output Instruction_D, PcPlus4_D, valid_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D,
             SignImm_D, pc_branch, branch
   );

   modport master (
      output Instruction_F, PcPlus4_F, stall_D, flush_D, RegWrite_W, WriteReg_W, Result_W,
      input  Instruction_D, PcPlus4_D, valid_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D,
             SignImm_D, pc_branch, branch
   );
endinterface

// File: rtl/mips_id_stage.sv
// MIPS decode stage: IF/ID latch, bypassed 32x32 regfile, sign-extend, beq/bne/j resolve.
// Latch output one cycle after load; reads/branch combinational; stall_D holds, flush_D wins.
module mips_id_stage #(
   parameter int            DW   = 32,
   parameter int            NREG = 32,
   parameter logic [DW-1:0] NOP  = '0
) (
   input logic            clk,
   input logic            rst,
   mips_id_stage_if.slave bus
);
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J   = 6'b000010;

   logic [DW-1:0] r_instr;
   logic [DW-1:0] r_pc4;
   logic          r_valid;
   logic [DW-1:0] r_regs [NREG];

   logic [4:0]    w_rs;
   logic [4:0]    w_rt;
   logic          w_wr_en;
   logic [DW-1:0] w_rd1;
   logic [DW-1:0] w_rd2;
   logic [DW-1:0] w_simm;
   logic [5:0]    w_op;
   logic          w_branch;
   logic [DW-1:0] w_target;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instr <= NOP;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (bus.flush_D) begin
         r_instr <= NOP;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (!bus.stall_D) begin
         r_instr <= bus.Instruction_F;
         r_pc4   <= bus.PcPlus4_F;
         r_valid <= 1'b1;
      end
   end

   assign w_wr_en = bus.RegWrite_W && (bus.WriteReg_W != 5'd0);

   // Register 0 is cleared on reset and excluded from writes, so it always reads zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[bus.WriteReg_W] <= bus.Result_W;
      end
   end

   assign w_rs   = r_instr[25:21];
   assign w_rt   = r_instr[20:16];
   assign w_op   = r_instr[31:26];
   assign w_simm = {{(DW-16){r_instr[15]}}, r_instr[15:0]};

   // Write-through: a same-cycle write-back to a source register is seen immediately.
   assign w_rd1 = (w_wr_en && bus.WriteReg_W == w_rs) ? bus.Result_W : r_regs[w_rs];
   assign w_rd2 = (w_wr_en && bus.WriteReg_W == w_rt) ? bus.Result_W : r_regs[w_rt];

   always_comb begin
      w_branch = 1'b0;
      w_target = '0;
      if (r_valid) begin
         case (w_op)
            OP_BEQ: begin
               w_branch = (w_rd1 == w_rd2);
               w_target = r_pc4 + {w_simm[DW-3:0], 2'b00};
            end
            OP_BNE: begin
               w_branch = (w_rd1 != w_rd2);
               w_target = r_pc4 + {w_simm[DW-3:0], 2'b00};
            end
            OP_J: begin
               w_branch = 1'b1;
               w_target = {r_pc4[DW-1:DW-4], r_instr[25:0], 2'b00};
            end
            default: begin
               w_branch = 1'b0;
               w_target = '0;
            end
         endcase
      end
   end

   assign bus.Instruction_D = r_instr;
   assign bus.PcPlus4_D     = r_pc4;
   assign bus.valid_D       = r_valid;
   assign bus.Rs_D          = w_rs;
   assign bus.Rt_D          = w_rt;
   assign bus.Rd_D          = r_instr[15:11];
   assign bus.RD1_D         = w_rd1;
   assign bus.RD2_D         = w_rd2;
   assign bus.SignImm_D     = w_simm;
   assign bus.pc_branch     = w_target;
   assign bus.branch        = w_branch;
endmodule

// File: tb/tb_mips_id_stage.sv
// Directed checks of the decode stage: reset, latch, regfile bypass, branch resolve, stall/flush.
module tb_mips_id_stage;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   mips_id_stage_if bus ();

   mips_id_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] instr, input logic [31:0] pc4);
      bus.Instruction_F = instr;
      bus.PcPlus4_F     = pc4;
      step();
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] val);
      bus.RegWrite_W = 1'b1;
      bus.WriteReg_W = idx;
      bus.Result_W   = val;
      step();
      bus.RegWrite_W = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      bus.Instruction_F = 32'hFFFF_FFFF;
      bus.PcPlus4_F     = 32'hFFFF_FFFF;
      bus.stall_D       = 1'b0;
      bus.flush_D       = 1'b0;
      bus.RegWrite_W    = 1'b0;
      bus.WriteReg_W    = 5'd0;
      bus.Result_W      = 32'h0;
      #3;
      chk("rst_instr",  bus.Instruction_D, 32'h0);
      chk("rst_pc4",    bus.PcPlus4_D, 32'h0);
      chk("rst_valid",  bus.valid_D, 32'h0);
      chk("rst_branch", bus.branch, 32'h0);
      chk("rst_target", bus.pc_branch, 32'h0);
      chk("rst_simm",   bus.SignImm_D, 32'h0);
      step();
      rst = 1'b1;

      // Every register reads zero after reset, via both read ports.
      for (int i = 0; i < 32; i++) begin
         logic [4:0] idx;
         idx = 5'(i);
         load({6'b001000, idx, idx, 16'h0}, 32'h0);
         chk("rst_rd1", bus.RD1_D, 32'h0);
         chk("rst_rd2", bus.RD2_D, 32'h0);
      end

      load(32'h2008_0005, 32'h4);
      chk("ld_instr", bus.Instruction_D, 32'h2008_0005);
      chk("ld_pc4",   bus.PcPlus4_D, 32'h4);
      chk("ld_rs",    bus.Rs_D, 32'd0);
      chk("ld_rt",    bus.Rt_D, 32'd8);
      chk("ld_rd",    bus.Rd_D, 32'd0);
      chk("ld_simm",  bus.SignImm_D, 32'h5);
      chk("ld_valid", bus.valid_D, 32'h1);
      chk("ld_branch", bus.branch, 32'h0);

      // Same-cycle bypass, then the stored value after the write edge.
      load(32'h0120_0000, 32'h8);
      bus.RegWrite_W = 1'b1;
      bus.WriteReg_W = 5'd9;
      bus.Result_W   = 32'hDEAD_BEEF;
      #1;
      chk("byp_rd1", bus.RD1_D, 32'hDEAD_BEEF);
      step();
      bus.RegWrite_W = 1'b0;
      #1;
      chk("stored_rd1", bus.RD1_D, 32'hDEAD_BEEF);

      load(32'h0000_0000, 32'hC);
      bus.RegWrite_W = 1'b1;
      bus.WriteReg_W = 5'd0;
      bus.Result_W   = 32'hFFFF_FFFF;
      #1;
      chk("r0_byp", bus.RD1_D, 32'h0);
      step();
      bus.RegWrite_W = 1'b0;
      #1;
      chk("r0_stored", bus.RD1_D, 32'h0);

      load(32'h0129_0000, 32'h10);
      bus.RegWrite_W = 1'b1;
      bus.WriteReg_W = 5'd9;
      bus.Result_W   = 32'h0000_1234;
      #1;
      chk("dual_rd1", bus.RD1_D, 32'h0000_1234);
      chk("dual_rd2", bus.RD2_D, 32'h0000_1234);
      bus.RegWrite_W = 1'b0;

      wr(5'd8, 32'd7);
      wr(5'd9, 32'd7);
      load(32'h1109_FFFF, 32'h100);
      chk("beq_rd1",    bus.RD1_D, 32'd7);
      chk("beq_rd2",    bus.RD2_D, 32'd7);
      chk("beq_simm",   bus.SignImm_D, 32'hFFFF_FFFF);
      chk("beq_rd",     bus.Rd_D, 32'd31);
      chk("beq_branch", bus.branch, 32'h1);
      chk("beq_target", bus.pc_branch, 32'h0000_00FC);

      load(32'h1509_FFFF, 32'h100);
      chk("bne_eq_branch", bus.branch, 32'h0);
      chk("bne_target",    bus.pc_branch, 32'h0000_00FC);
      // A differing write-back to Rt flips bne via the bypass path.
      bus.RegWrite_W = 1'b1;
      bus.WriteReg_W = 5'd9;
      bus.Result_W   = 32'd8;
      #1;
      chk("bne_byp_branch", bus.branch, 32'h1);
      step();
      bus.RegWrite_W = 1'b0;

      load(32'h1109_0010, 32'h200);
      chk("beq_ne_branch", bus.branch, 32'h0);
      chk("beq_fwd_target", bus.pc_branch, 32'h0000_0240);

      load(32'h0800_0040, 32'h1000_0008);
      chk("j_branch", bus.branch, 32'h1);
      chk("j_target", bus.pc_branch, 32'h1000_0100);

      bus.stall_D       = 1'b1;
      bus.Instruction_F = 32'hAAAA_AAAA;
      bus.PcPlus4_F     = 32'h5555_5554;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stall_instr",  bus.Instruction_D, 32'h0800_0040);
         chk("stall_pc4",    bus.PcPlus4_D, 32'h1000_0008);
         chk("stall_branch", bus.branch, 32'h1);
      end

      bus.flush_D = 1'b1;
      #1;
      chk("flush_pre_branch", bus.branch, 32'h1);
      step();
      chk("flush_instr",  bus.Instruction_D, 32'h0);
      chk("flush_pc4",    bus.PcPlus4_D, 32'h0);
      chk("flush_valid",  bus.valid_D, 32'h0);
      chk("flush_branch", bus.branch, 32'h0);
      chk("flush_target", bus.pc_branch, 32'h0);
      bus.flush_D = 1'b0;
      bus.stall_D = 1'b0;

      load(32'h2008_0005, 32'h4);
      chk("reld_valid", bus.valid_D, 32'h1);
      bus.stall_D = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_instr", bus.Instruction_D, 32'h0);
      chk("arst_pc4",   bus.PcPlus4_D, 32'h0);
      chk("arst_valid", bus.valid_D, 32'h0);
      step();
      rst = 1'b1;
      bus.stall_D = 1'b0;
      load(32'h0128_0000, 32'h4);
      chk("arst_rd1", bus.RD1_D, 32'h0);
      chk("arst_rd2", bus.RD2_D, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
